// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer and its datapath.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] PCSEL_PC4 = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;
    localparam logic [1:0] PCSEL_REG = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [2:0] WA_RT = 3'b000;
    localparam logic [2:0] WA_RD = 3'b001;
    localparam logic [2:0] WA_RA = 3'b010;

    localparam logic [2:0] WD_ALU   = 3'b000;
    localparam logic [2:0] WD_DM    = 3'b001;
    localparam logic [2:0] WD_PC    = 3'b010;
    localparam logic [2:0] WD_SHIFT = 3'b011;

    // One-hot instruction class; exactly one bit set for any opcode/funct.
    typedef struct packed {
        logic rtype_alu;
        logic sll;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;
    } ins_class_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct to one-hot instruction class.
// Latency: combinational.
// Backpressure: none.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output ins_class_t  cls
);

    // Classify the latched instruction; anything unrecognised is illegal.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: cls.rtype_alu = 1'b1;
                    FN_SLL:           cls.sll       = 1'b1;
                    FN_JR:            cls.jr        = 1'b1;
                    default:          cls.illegal   = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori     = 1'b1;
            OP_LUI:  cls.lui     = 1'b1;
            OP_LW:   cls.lw      = 1'b1;
            OP_SW:   cls.sw      = 1'b1;
            OP_BEQ:  cls.beq     = 1'b1;
            OP_J:    cls.j       = 1'b1;
            OP_JAL:  cls.jal     = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM plus retire counter.
// Latency: outputs combinational from state and inputs; state/count update each clk.
// Backpressure: holds in MEM while dm_ready is low; dm_ready ignored elsewhere.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Equal,
    input  logic             dm_ready,
    output logic             PCWrite,
    output logic [1:0]       PCSel,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             dm_req,
    output logic             ALUSrc,
    output logic [2:0]       ALUSelect,
    output logic             EXTSelect,
    output logic [2:0]       GRF_WASrc,
    output logic [2:0]       GRF_WDSrc,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    ins_class_t cls;
    state_t     cur_state;
    state_t     nxt_state;
    logic       retire;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

    assign state = cur_state;

    // Next-state and per-state control outputs; enables are squashed during reset.
    always_comb begin
        nxt_state = cur_state;
        PCWrite   = 1'b0;
        PCSel     = PCSEL_PC4;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        dm_req    = 1'b0;
        ALUSrc    = 1'b0;
        ALUSelect = ALU_ADD;
        EXTSelect = 1'b0;
        GRF_WASrc = WA_RT;
        GRF_WDSrc = WD_ALU;

        case (cur_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                nxt_state = S_DECODE;
            end
            S_DECODE: begin
                if (cls.j) begin
                    PCWrite   = 1'b1;
                    PCSel     = PCSEL_JMP;
                    nxt_state = S_FETCH;
                end else if (cls.jal) begin
                    PCWrite   = 1'b1;
                    PCSel     = PCSEL_JMP;
                    RegWrite  = 1'b1;
                    GRF_WASrc = WA_RA;
                    GRF_WDSrc = WD_PC;
                    nxt_state = S_FETCH;
                end else if (cls.jr) begin
                    PCWrite   = 1'b1;
                    PCSel     = PCSEL_REG;
                    nxt_state = S_FETCH;
                end else if (cls.illegal) begin
                    nxt_state = S_FETCH;
                end else begin
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.beq) begin
                    PCWrite   = Equal;
                    PCSel     = PCSEL_BR;
                    nxt_state = S_FETCH;
                end else if (cls.lw || cls.sw) begin
                    nxt_state = S_MEM;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_MEM: begin
                dm_req   = 1'b1;
                MemWrite = cls.sw;
                if (dm_ready) begin
                    nxt_state = cls.lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                GRF_WASrc = (cls.rtype_alu || cls.sll) ? WA_RD : WA_RT;
                if (cls.lw) begin
                    GRF_WDSrc = WD_DM;
                end else if (cls.sll) begin
                    GRF_WDSrc = WD_SHIFT;
                end else begin
                    GRF_WDSrc = WD_ALU;
                end
                nxt_state = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase

        // ALU controls stay fixed from EXEC through WB so ALU_Y and the DM address are stable.
        if (cur_state == S_EXEC || cur_state == S_MEM || cur_state == S_WB) begin
            if (cls.beq) begin
                ALUSelect = ALU_SUB;
            end else if (cls.lw || cls.sw) begin
                ALUSrc    = 1'b1;
                EXTSelect = 1'b1;
                ALUSelect = ALU_ADD;
            end else if (cls.ori) begin
                ALUSrc    = 1'b1;
                ALUSelect = ALU_OR;
            end else if (cls.lui) begin
                ALUSrc    = 1'b1;
                ALUSelect = ALU_LUI;
            end else if (cls.rtype_alu) begin
                ALUSelect = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
        end

        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            dm_req   = 1'b0;
        end
    end

    // An instruction retires whenever a legal working state hands back to FETCH.
    assign retire = (nxt_state == S_FETCH) &&
                    (cur_state == S_DECODE || cur_state == S_EXEC ||
                     cur_state == S_MEM    || cur_state == S_WB);

    // State register and wrapping retire counter; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= S_FETCH;
            instr_count <= '0;
        end else begin
            cur_state <= nxt_state;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule
